// File: rtl/ama_riscv_bp_spec_tracker.sv
// Branch-predictor speculation tracker: in-order queue of predicted branches between decode and
// memory stage. Optional saturating statistics counters under AMA_RISCV_SPEC_STATS_EN.
package ama_riscv_bp_spec_tracker_pkg;
  parameter int unsigned BP_PC_W = 32;

  typedef enum logic {B_NT = 1'b0, B_T = 1'b1} branch_t;

  typedef struct packed {
    logic enter;
    logic resolve;
  } bp_spec_t;

  typedef struct packed {
    logic [BP_PC_W-1:0] pc_dec;
    logic [BP_PC_W-1:0] pc_mem;
    branch_t            br_res;
    bp_spec_t           spec;
  } bp_pipe_t;
endpackage

module ama_riscv_bp_spec_tracker
  import ama_riscv_bp_spec_tracker_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PC_W  = BP_PC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec_br_valid,
  input  logic            dec_stall,
  input  logic [PC_W-1:0] dec_pc,
  input  branch_t         dec_pred,
  input  logic [PC_W-1:0] dec_target,
  input  logic            res_valid,
  input  branch_t         res_taken,
  input  logic [PC_W-1:0] res_target,
  output bp_pipe_t        pipe_out,
  output logic            spec_full,
  output logic            mispred,
  output logic [PC_W-1:0] redirect_pc,
  output logic            spec_err,
  output logic [31:0]     stat_resolved,
  output logic [31:0]     stat_mispred
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PC_W-1:0]  q_pc_q   [DEPTH];
  logic [PC_W-1:0]  q_pc_d   [DEPTH];
  branch_t          q_pred_q [DEPTH];
  branch_t          q_pred_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mispred_q, mispred_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic             spec_err_q, spec_err_d;

  logic             empty;
  logic             enter;
  logic             resolve;
  logic             mispred_kill;
  logic [PC_W-1:0]  head_pc;
  branch_t          head_pred;

  // The decode-side target is not needed here; the predictor consumes it elsewhere.
  logic unused_dec_target;
  assign unused_dec_target = ^dec_target;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty        = (count_q == '0);
    spec_full    = (count_q == CNT_FULL);
    head_pc      = q_pc_q[rd_ptr_q];
    head_pred    = q_pred_q[rd_ptr_q];
    resolve      = res_valid && !empty;
    mispred_kill = resolve && (res_taken != head_pred);
    // A mispredict squashes the decode branch too: it is younger than the resolving one.
    enter        = dec_br_valid && !dec_stall && !spec_full && !mispred_kill;
  end

  always_comb begin
    q_pc_d        = q_pc_q;
    q_pred_d      = q_pred_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    mispred_d     = mispred_kill;
    redirect_pc_d = redirect_pc_q;
    spec_err_d    = spec_err_q | (res_valid & empty);

    if (mispred_kill) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      redirect_pc_d = (res_taken == B_T) ? res_target : head_pc + PC_W'(4);
    end else begin
      if (enter) begin
        q_pc_d[wr_ptr_q]   = dec_pc;
        q_pred_d[wr_ptr_q] = dec_pred;
        wr_ptr_d           = ptr_inc(wr_ptr_q);
      end
      if (resolve) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(enter) - CNT_W'(resolve);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_pc_q[i]   <= '0;
        q_pred_q[i] <= B_NT;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      mispred_q     <= 1'b0;
      redirect_pc_q <= '0;
      spec_err_q    <= 1'b0;
    end else begin
      q_pc_q        <= q_pc_d;
      q_pred_q      <= q_pred_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mispred_q     <= mispred_d;
      redirect_pc_q <= redirect_pc_d;
      spec_err_q    <= spec_err_d;
    end
  end

  always_comb begin
    pipe_out.pc_dec       = BP_PC_W'(dec_pc);
    pipe_out.pc_mem       = empty ? '0 : BP_PC_W'(head_pc);
    pipe_out.br_res       = res_taken;
    pipe_out.spec.enter   = enter;
    pipe_out.spec.resolve = resolve;
  end

  assign mispred     = mispred_q;
  assign redirect_pc = redirect_pc_q;
  assign spec_err    = spec_err_q;

`ifdef AMA_RISCV_SPEC_STATS_EN
  logic [31:0] stat_res_q, stat_res_d;
  logic [31:0] stat_mis_q, stat_mis_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    stat_res_d = stat_res_q;
    stat_mis_d = stat_mis_q;
    if (resolve && (stat_res_q != '1)) begin
      stat_res_d = stat_res_q + 32'd1;
    end
    if (mispred_kill && (stat_mis_q != '1)) begin
      stat_mis_d = stat_mis_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_res_q <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_res_q <= stat_res_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_resolved = stat_res_q;
  assign stat_mispred  = stat_mis_q;
`else
  assign stat_resolved = '0;
  assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_ama_riscv_bp_spec_tracker.sv
// Bench for ama_riscv_bp_spec_tracker: directed vector table, async-reset and stats sequences,
// then randomized traffic against a queue-based reference model.
module tb_ama_riscv_bp_spec_tracker;
  import ama_riscv_bp_spec_tracker_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned PC_W  = 32;
`ifdef AMA_RISCV_SPEC_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            dec_br_valid, dec_stall, res_valid;
  logic [PC_W-1:0] dec_pc, dec_target, res_target;
  branch_t         dec_pred, res_taken;
  bp_pipe_t        pipe_out;
  logic            spec_full, mispred, spec_err;
  logic [PC_W-1:0] redirect_pc;
  logic [31:0]     stat_resolved, stat_mispred;

  int n_checks = 0;
  int n_fail   = 0;

  ama_riscv_bp_spec_tracker #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .dec_br_valid (dec_br_valid),
    .dec_stall    (dec_stall),
    .dec_pc       (dec_pc),
    .dec_pred     (dec_pred),
    .dec_target   (dec_target),
    .res_valid    (res_valid),
    .res_taken    (res_taken),
    .res_target   (res_target),
    .pipe_out     (pipe_out),
    .spec_full    (spec_full),
    .mispred      (mispred),
    .redirect_pc  (redirect_pc),
    .spec_err     (spec_err),
    .stat_resolved(stat_resolved),
    .stat_mispred (stat_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dbv;
    logic        stall;
    logic [31:0] dpc;
    branch_t     dpred;
    logic        rv;
    branch_t     rtaken;
    logic [31:0] rtgt;
    logic        e_enter;
    logic        e_resolve;
    logic        e_full;
    logic [31:0] e_pc_mem;
    logic        e_mispred;
    logic [31:0] e_redirect;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    branch_t     pred;
  } entry_t;

  vec_t   tbl[$];
  entry_t m_q[$];

  function automatic vec_t mk(logic dbv, logic stall, logic [31:0] dpc, branch_t dpred,
                              logic rv, branch_t rtaken, logic [31:0] rtgt,
                              logic e_enter, logic e_resolve, logic e_full,
                              logic [31:0] e_pc_mem, logic e_mispred, logic [31:0] e_redirect,
                              logic e_err);
    vec_t v;
    v.dbv = dbv; v.stall = stall; v.dpc = dpc; v.dpred = dpred;
    v.rv = rv; v.rtaken = rtaken; v.rtgt = rtgt;
    v.e_enter = e_enter; v.e_resolve = e_resolve; v.e_full = e_full;
    v.e_pc_mem = e_pc_mem; v.e_mispred = e_mispred; v.e_redirect = e_redirect; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic dbv, input logic stall, input logic [31:0] dpc,
                       input branch_t dpred, input logic rv, input branch_t rtaken,
                       input logic [31:0] rtgt);
    dec_br_valid = dbv;
    dec_stall    = stall;
    dec_pc       = dpc;
    dec_pred     = dpred;
    dec_target   = dpc + 32'h40;
    res_valid    = rv;
    res_taken    = rtaken;
    res_target   = rtgt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, B_NT, 1'b0, B_NT, 32'h0);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic        m_mis, m_err;
    logic [31:0] m_redir;
    int          m_nres, m_nmis;

    idle();
    #1;
    chk("reset_full", spec_full, 0);
    chk("reset_pc_mem", pipe_out.pc_mem, 0);
    chk("reset_enter", pipe_out.spec.enter, 0);
    chk("reset_resolve", pipe_out.spec.resolve, 0);
    chk("reset_mispred", mispred, 0);
    chk("reset_redirect", redirect_pc, 0);
    chk("reset_err", spec_err, 0);
    chk("reset_stat_res", stat_resolved, 0);
    chk("reset_stat_mis", stat_mispred, 0);
    reset_dut();

    // Directed table: each row is one cycle; registered columns are the values seen during it.
    tbl.push_back(mk(0,0,32'h0,B_NT,       0,B_NT,32'h0,     0,0,0,32'h0,       0,32'h0,0));
    tbl.push_back(mk(1,0,32'h100,B_T,      0,B_NT,32'h0,     1,0,0,32'h0,       0,32'h0,0));
    tbl.push_back(mk(0,0,32'h0,B_NT,       0,B_NT,32'h0,     0,0,0,32'h100,     0,32'h0,0));
    tbl.push_back(mk(0,0,32'h0,B_NT,       1,B_T,32'h0,      0,1,0,32'h100,     0,32'h0,0));
    tbl.push_back(mk(0,0,32'h0,B_NT,       0,B_NT,32'h0,     0,0,0,32'h0,       0,32'h0,0));
    tbl.push_back(mk(1,0,32'h200,B_T,      0,B_NT,32'h0,     1,0,0,32'h0,       0,32'h0,0));
    tbl.push_back(mk(0,0,32'h0,B_NT,       1,B_NT,32'h999,   0,1,0,32'h200,     0,32'h0,0));
    tbl.push_back(mk(0,0,32'h0,B_NT,       0,B_NT,32'h0,     0,0,0,32'h0,       1,32'h204,0));
    tbl.push_back(mk(0,0,32'h0,B_NT,       0,B_NT,32'h0,     0,0,0,32'h0,       0,32'h204,0));
    tbl.push_back(mk(1,0,32'h300,B_NT,     0,B_NT,32'h0,     1,0,0,32'h0,       0,32'h204,0));
    tbl.push_back(mk(0,0,32'h0,B_NT,       1,B_T,32'h400,    0,1,0,32'h300,     0,32'h204,0));
    tbl.push_back(mk(0,0,32'h0,B_NT,       0,B_NT,32'h0,     0,0,0,32'h0,       1,32'h400,0));
    tbl.push_back(mk(1,0,32'h10,B_T,       0,B_NT,32'h0,     1,0,0,32'h0,       0,32'h400,0));
    tbl.push_back(mk(1,0,32'h20,B_T,       0,B_NT,32'h0,     1,0,0,32'h10,      0,32'h400,0));
    tbl.push_back(mk(1,0,32'h30,B_T,       0,B_NT,32'h0,     0,0,1,32'h10,      0,32'h400,0));
    tbl.push_back(mk(1,0,32'h30,B_T,       1,B_T,32'h0,      0,1,1,32'h10,      0,32'h400,0));
    tbl.push_back(mk(1,0,32'h30,B_T,       0,B_NT,32'h0,     1,0,0,32'h20,      0,32'h400,0));
    tbl.push_back(mk(0,0,32'h0,B_NT,       1,B_T,32'h0,      0,1,1,32'h20,      0,32'h400,0));
    tbl.push_back(mk(1,0,32'h40,B_T,       0,B_NT,32'h0,     1,0,0,32'h30,      0,32'h400,0));
    tbl.push_back(mk(1,0,32'h50,B_T,       1,B_NT,32'h777,   0,1,1,32'h30,      0,32'h400,0));
    tbl.push_back(mk(0,0,32'h0,B_NT,       0,B_NT,32'h0,     0,0,0,32'h0,       1,32'h34,0));
    tbl.push_back(mk(1,0,32'h60,B_NT,      0,B_NT,32'h0,     1,0,0,32'h0,       0,32'h34,0));
    tbl.push_back(mk(1,0,32'h70,B_T,       1,B_T,32'h800,    0,1,0,32'h60,      0,32'h34,0));
    tbl.push_back(mk(0,0,32'h0,B_NT,       0,B_NT,32'h0,     0,0,0,32'h0,       1,32'h800,0));
    tbl.push_back(mk(0,0,32'h0,B_NT,       0,B_NT,32'h0,     0,0,0,32'h0,       0,32'h800,0));
    tbl.push_back(mk(1,1,32'h90,B_T,       0,B_NT,32'h0,     0,0,0,32'h0,       0,32'h800,0));
    tbl.push_back(mk(0,0,32'h0,B_NT,       0,B_NT,32'h0,     0,0,0,32'h0,       0,32'h800,0));
    tbl.push_back(mk(0,0,32'h0,B_NT,       1,B_T,32'h0,      0,0,0,32'h0,       0,32'h800,0));
    tbl.push_back(mk(0,0,32'h0,B_NT,       0,B_NT,32'h0,     0,0,0,32'h0,       0,32'h800,1));
    tbl.push_back(mk(1,0,32'hFFFF_FFFC,B_T,0,B_NT,32'h0,     1,0,0,32'h0,       0,32'h800,1));
    tbl.push_back(mk(0,0,32'h0,B_NT,       1,B_NT,32'h0,     0,1,0,32'hFFFF_FFFC,0,32'h800,1));
    tbl.push_back(mk(0,0,32'h0,B_NT,       0,B_NT,32'h0,     0,0,0,32'h0,       1,32'h0,1));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].dbv, tbl[i].stall, tbl[i].dpc, tbl[i].dpred,
            tbl[i].rv, tbl[i].rtaken, tbl[i].rtgt);
      #1;
      chk($sformatf("t%0d_enter", i), pipe_out.spec.enter, tbl[i].e_enter);
      chk($sformatf("t%0d_resolve", i), pipe_out.spec.resolve, tbl[i].e_resolve);
      chk($sformatf("t%0d_full", i), spec_full, tbl[i].e_full);
      chk($sformatf("t%0d_pc_mem", i), pipe_out.pc_mem, tbl[i].e_pc_mem);
      chk($sformatf("t%0d_mispred", i), mispred, tbl[i].e_mispred);
      chk($sformatf("t%0d_redirect", i), redirect_pc, tbl[i].e_redirect);
      chk($sformatf("t%0d_err", i), spec_err, tbl[i].e_err);
      chk($sformatf("t%0d_pc_dec", i), pipe_out.pc_dec, tbl[i].dpc);
      chk($sformatf("t%0d_br_res", i), pipe_out.br_res, tbl[i].rtaken);
    end
    chk("tbl_stat_res", stat_resolved, StatsEn ? 8 : 0);
    chk("tbl_stat_mis", stat_mispred, StatsEn ? 5 : 0);

    // Asynchronous reset while mispred and spec_err are both high.
    reset_dut();
    drive(1'b0, 1'b0, 32'h0, B_NT, 1'b1, B_T, 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'hA0, B_NT, 1'b0, B_NT, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, B_NT, 1'b1, B_T, 32'hB0);
    @(negedge clk);
    idle();
    #1;
    chk("arst_pre_mispred", mispred, 1);
    chk("arst_pre_err", spec_err, 1);
    chk("arst_pre_redirect", redirect_pc, 32'hB0);
    #1 rst = 1'b0;
    #1;
    chk("arst_mispred", mispred, 0);
    chk("arst_err", spec_err, 0);
    chk("arst_redirect", redirect_pc, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'hC0, B_T, 1'b0, B_NT, 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("arst_pre_pc_mem", pipe_out.pc_mem, 32'hC0);
    #1 rst = 1'b0;
    #1;
    chk("arst_pc_mem", pipe_out.pc_mem, 0);
    chk("arst_full", spec_full, 0);
    @(negedge clk);
    rst = 1'b1;

    // Stats: five resolves, the first two mispredicting.
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'h1000 + 32'(i * 8), B_T, 1'b0, B_NT, 32'h0);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, B_NT, 1'b1, (i < 2) ? B_NT : B_T, 32'h500);
      @(negedge clk);
    end
    idle();
    #1;
    chk("stat_resolved", stat_resolved, StatsEn ? 5 : 0);
    chk("stat_mispred", stat_mispred, StatsEn ? 2 : 0);

    // Randomized traffic against the reference queue.
    reset_dut();
    m_q.delete();
    m_mis = 1'b0; m_err = 1'b0; m_redir = 32'h0; m_nres = 0; m_nmis = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      logic        dbv, stall, rv, full, res, kill, ent;
      logic [31:0] dpc, rtgt, pcm;
      branch_t     dpred, rtaken;
      @(negedge clk);
      dbv   = ($urandom_range(0, 1) == 1);
      stall = ($urandom_range(0, 4) == 0);
      dpc   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      dpred = branch_t'($urandom_range(0, 1));
      rv    = ($urandom_range(0, 9) < 4);
      rtgt  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if (m_q.size() > 0 && $urandom_range(0, 3) != 0) rtaken = m_q[0].pred;
      else rtaken = branch_t'($urandom_range(0, 1));
      drive(dbv, stall, dpc, dpred, rv, rtaken, rtgt);
      #1;
      full = (m_q.size() == DEPTH);
      res  = rv && (m_q.size() > 0);
      kill = res && (rtaken != m_q[0].pred);
      ent  = dbv && !stall && !full && !kill;
      pcm  = (m_q.size() > 0) ? m_q[0].pc : 32'h0;
      chk("rnd_enter", pipe_out.spec.enter, ent);
      chk("rnd_resolve", pipe_out.spec.resolve, res);
      chk("rnd_full", spec_full, full);
      chk("rnd_pc_mem", pipe_out.pc_mem, pcm);
      chk("rnd_mispred", mispred, m_mis);
      chk("rnd_redirect", redirect_pc, m_redir);
      chk("rnd_err", spec_err, m_err);
      chk("rnd_pc_dec", pipe_out.pc_dec, dpc);
      // Model state after the coming clock edge.
      m_mis = kill;
      if (rv && m_q.size() == 0) m_err = 1'b1;
      if (res) m_nres++;
      if (kill) begin
        m_nmis++;
        m_redir = (rtaken == B_T) ? rtgt : m_q[0].pc + 32'd4;
        m_q.delete();
      end else begin
        entry_t e;
        if (res) void'(m_q.pop_front());
        e.pc = dpc;
        e.pred = dpred;
        if (ent) m_q.push_back(e);
      end
    end
    @(negedge clk);
    idle();
    #1;
    chk("rnd_mispred_last", mispred, m_mis);
    chk("rnd_redirect_last", redirect_pc, m_redir);
    chk("rnd_stat_res", stat_resolved, StatsEn ? m_nres : 0);
    chk("rnd_stat_mis", stat_mispred, StatsEn ? m_nmis : 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
